// File: rtl/ssd_scan_mux_if.sv
// Frame-load and scan-output bundle for the seven-segment scan controller.
// The testbench drives through master; the controller uses slave.
interface ssd_scan_mux_if;
    logic [31:0] frame_in;
    logic [7:0]  dp_in;
    logic [7:0]  en_in;
    logic        load;
    logic        load_ack;
    logic [3:0]  bcd;
    logic [7:0]  an;
    logic        dp;
    logic [2:0]  digit_idx;
    logic        frame_tick;

    modport master (
        output frame_in, dp_in, en_in, load,
        input  load_ack, bcd, an, dp, digit_idx, frame_tick
    );

    modport slave (
        input  frame_in, dp_in, en_in, load,
        output load_ack, bcd, an, dp, digit_idx, frame_tick
    );
endinterface

// File: rtl/ssd_scan_mux.sv
// 8-digit common-anode scan controller with a double-buffered frame,
// a per-slot anode blanking guard and leading-zero suppression.
module ssd_scan_mux #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2000,
    parameter int LZ_BLANK     = 1
) (
    input logic           clk,
    input logic           rst_n,
    ssd_scan_mux_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] TC_C = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [31:0]   pend_code, sh_code;
    logic [7:0]    pend_dp, pend_en, sh_dp, sh_en, lz_mask;
    logic          pending;

    logic          tc, wrap, upd, lit;
    logic [31:0]   new_code;
    logic [7:0]    new_dp, new_en, lz_next, an_next;

    assign tc   = (cnt == TC_C);
    assign wrap = tc && (idx == 3'd7);
    assign upd  = wrap && (pending || bus.load);

    // A load landing on the wrap edge goes straight to the shadow.
    assign new_code = bus.load ? bus.frame_in : pend_code;
    assign new_dp   = bus.load ? bus.dp_in    : pend_dp;
    assign new_en   = bus.load ? bus.en_in    : pend_en;

    generate
        if (BLANK_CYCLES == 0) begin : g_noblank
            assign lit = 1'b1;
        end else begin : g_blank
            localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);
            assign lit = (cnt >= BLANK_C);
        end
    endgenerate

    // Suppress zeros from the top digit down; digit 0 always shows.
    always_comb begin
        logic zrun;
        lz_next = '0;
        zrun    = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            zrun       = zrun && (new_code[4*i +: 4] == 4'h0);
            lz_next[i] = zrun;
        end
        if (LZ_BLANK == 0) lz_next = '0;
    end

    always_comb begin
        an_next = '1;
        if (sh_en[idx] && lit) an_next[idx] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            idx            <= '0;
            pend_code      <= '1;
            pend_dp        <= '0;
            pend_en        <= '0;
            pending        <= 1'b0;
            sh_code        <= '1;
            sh_dp          <= '0;
            sh_en          <= '0;
            lz_mask        <= '0;
            bus.an         <= '1;
            bus.bcd        <= 4'hF;
            bus.dp         <= 1'b1;
            bus.load_ack   <= 1'b0;
            bus.frame_tick <= 1'b0;
        end else begin
            cnt <= tc ? '0 : cnt + 1'b1;
            if (tc) idx <= idx + 3'd1;

            if (upd) begin
                sh_code <= new_code;
                sh_dp   <= new_dp;
                sh_en   <= new_en;
                lz_mask <= lz_next;
                pending <= 1'b0;
            end else if (bus.load) begin
                pend_code <= bus.frame_in;
                pend_dp   <= bus.dp_in;
                pend_en   <= bus.en_in;
                pending   <= 1'b1;
            end

            bus.load_ack   <= upd;
            bus.frame_tick <= wrap;
            bus.an         <= an_next;
            bus.bcd        <= lz_mask[idx] ? 4'hF : sh_code[4*idx +: 4];
            bus.dp         <= ~(sh_dp[idx] & sh_en[idx]);
        end
    end

    assign bus.digit_idx = idx;
endmodule
